// File: rtl/rob_pkg.sv
// Reorder-buffer sizing, pointer type and per-entry storage layout.
// Shared by rob and rob_entry.
package rob_pkg;

  localparam int ROB_DEPTH      = 8;
  localparam int ROB_PTR_WIDTH  = 3;
  localparam int ROB_CNT_WIDTH  = ROB_PTR_WIDTH + 1;
  localparam int WORD_WIDTH     = 32;
  localparam int GPR_ADDR_WIDTH = 5;

  // Entry index plus one wrap bit above it.
  typedef logic [ROB_PTR_WIDTH:0] rob_ptr_t;

  typedef struct packed {
    logic                      valid;
    logic                      done;
    logic                      has_dst;
    logic [GPR_ADDR_WIDTH-1:0] dst_addr;
    logic [WORD_WIDTH-1:0]     value;
  } rob_entry_t;

  function automatic rob_ptr_t ptr_inc(input rob_ptr_t p);
    return p + rob_ptr_t'(1);
  endfunction

endpackage

// File: rtl/rob_entry.sv
// Single reorder-buffer slot: valid/done/has_dst/dst_addr/value.
// Priority: flush > alloc > clear > writeback; writeback lands only on a valid slot.
module rob_entry
  import rob_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_alloc,
  input  logic                      i_alloc_has_dst,
  input  logic [GPR_ADDR_WIDTH-1:0] i_alloc_dst_addr,
  input  logic                      i_wb,
  input  logic [WORD_WIDTH-1:0]     i_wb_value,
  input  logic                      i_clear,
  input  logic                      i_flush,
  output rob_entry_t                o_entry
);

  rob_entry_t r_entry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_entry <= '0;
    end else if (i_flush) begin
      r_entry <= '0;
    end else if (i_alloc) begin
      r_entry.valid    <= 1'b1;
      r_entry.done     <= 1'b0;
      r_entry.has_dst  <= i_alloc_has_dst;
      r_entry.dst_addr <= i_alloc_dst_addr;
      r_entry.value    <= '0;
    end else if (i_clear) begin
      r_entry <= '0;
    end else if (i_wb && r_entry.valid) begin
      // A second writeback to the same slot simply overwrites the value.
      r_entry.done  <= 1'b1;
      r_entry.value <= i_wb_value;
    end
  end

  assign o_entry = r_entry;

endmodule

// File: rtl/rob.sv
// In-order retirement buffer feeding the GPR write port; one retire per cycle.
// Optional flush port is built only when ROB_FLUSH_EN is defined.
module rob
  import rob_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dispatch_valid,
  input  logic                      dispatch_has_dst,
  input  logic [GPR_ADDR_WIDTH-1:0] dispatch_dst_addr,
  output logic                      dispatch_ready,
  output logic [ROB_PTR_WIDTH-1:0]  dispatch_tag,
  input  logic                      wb_valid,
  input  logic [ROB_PTR_WIDTH-1:0]  wb_tag,
  input  logic [WORD_WIDTH-1:0]     wb_value,
`ifdef ROB_FLUSH_EN
  input  logic                      flush,
`endif
  output logic                      commit_en,
  output logic [GPR_ADDR_WIDTH-1:0] rob_commit_dst_addr,
  output logic [WORD_WIDTH-1:0]     rob_commit_dst_value,
  output logic                      rob_empty,
  output logic [ROB_CNT_WIDTH-1:0]  rob_count
);

  rob_ptr_t                   r_head;
  rob_ptr_t                   r_tail;
  logic [ROB_CNT_WIDTH-1:0]   r_count;

  rob_entry_t                 w_entry [ROB_DEPTH];
  rob_entry_t                 w_head_entry;
  logic [ROB_PTR_WIDTH-1:0]   w_head_idx;
  logic [ROB_PTR_WIDTH-1:0]   w_tail_idx;
  logic                       w_flush;
  logic                       w_alloc;
  logic                       w_retire;
  logic [ROB_DEPTH-1:0]       w_alloc_dec;
  logic [ROB_DEPTH-1:0]       w_clear_dec;
  logic [ROB_DEPTH-1:0]       w_wb_dec;

`ifdef ROB_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_head_idx   = r_head[ROB_PTR_WIDTH-1:0];
  assign w_tail_idx   = r_tail[ROB_PTR_WIDTH-1:0];
  assign w_head_entry = w_entry[w_head_idx];

  // Ready looks only at the registered count, so a full buffer stays full
  // for the cycle in which its head retires.
  assign dispatch_ready = (r_count != ROB_CNT_WIDTH'(ROB_DEPTH));
  assign dispatch_tag   = w_tail_idx;
  assign rob_empty      = (r_count == '0);
  assign rob_count      = r_count;

  assign w_alloc  = dispatch_valid & dispatch_ready & ~w_flush;
  assign w_retire = w_head_entry.valid & w_head_entry.done & ~w_flush;

  always_comb begin
    w_alloc_dec = '0;
    w_clear_dec = '0;
    w_wb_dec    = '0;
    for (int i = 0; i < ROB_DEPTH; i++) begin
      w_alloc_dec[i] = w_alloc  && (w_tail_idx == ROB_PTR_WIDTH'(i));
      w_clear_dec[i] = w_retire && (w_head_idx == ROB_PTR_WIDTH'(i));
      w_wb_dec[i]    = wb_valid && (wb_tag     == ROB_PTR_WIDTH'(i));
    end
  end

  for (genvar g = 0; g < ROB_DEPTH; g++) begin : g_entry
    rob_entry u_entry (
      .clk              (clk),
      .rst              (rst),
      .i_alloc          (w_alloc_dec[g]),
      .i_alloc_has_dst  (dispatch_has_dst),
      .i_alloc_dst_addr (dispatch_dst_addr),
      .i_wb             (w_wb_dec[g]),
      .i_wb_value       (wb_value),
      .i_clear          (w_clear_dec[g]),
      .i_flush          (w_flush),
      .o_entry          (w_entry[g])
    );
  end

  // Commit is combinational off the registered head so the GPR file can
  // bypass the value in the same cycle; x0 and no-dst entries retire silently.
  always_comb begin
    commit_en            = 1'b0;
    rob_commit_dst_addr  = '0;
    rob_commit_dst_value = '0;
    if (w_retire && w_head_entry.has_dst && (w_head_entry.dst_addr != '0)) begin
      commit_en            = 1'b1;
      rob_commit_dst_addr  = w_head_entry.dst_addr;
      rob_commit_dst_value = w_head_entry.value;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_tail  <= r_head;
      r_count <= '0;
    end else begin
      if (w_alloc) begin
        r_tail <= ptr_inc(r_tail);
      end
      if (w_retire) begin
        r_head <= ptr_inc(r_head);
      end
      case ({w_alloc, w_retire})
        2'b10:   r_count <= r_count + ROB_CNT_WIDTH'(1);
        2'b01:   r_count <= r_count - ROB_CNT_WIDTH'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_rob.sv
// Directed self-checking bench for rob; flush scenario compiled in with ROB_FLUSH_EN.
module tb_rob;
  import rob_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      dispatch_valid = 1'b0;
  logic                      dispatch_has_dst = 1'b0;
  logic [GPR_ADDR_WIDTH-1:0] dispatch_dst_addr = '0;
  logic                      dispatch_ready;
  logic [ROB_PTR_WIDTH-1:0]  dispatch_tag;
  logic                      wb_valid = 1'b0;
  logic [ROB_PTR_WIDTH-1:0]  wb_tag = '0;
  logic [WORD_WIDTH-1:0]     wb_value = '0;
`ifdef ROB_FLUSH_EN
  logic                      flush = 1'b0;
`endif
  logic                      commit_en;
  logic [GPR_ADDR_WIDTH-1:0] rob_commit_dst_addr;
  logic [WORD_WIDTH-1:0]     rob_commit_dst_value;
  logic                      rob_empty;
  logic [ROB_CNT_WIDTH-1:0]  rob_count;

  int n_checks = 0;
  int n_errors = 0;

  rob dut (
    .clk                  (clk),
    .rst                  (rst),
    .dispatch_valid       (dispatch_valid),
    .dispatch_has_dst     (dispatch_has_dst),
    .dispatch_dst_addr    (dispatch_dst_addr),
    .dispatch_ready       (dispatch_ready),
    .dispatch_tag         (dispatch_tag),
    .wb_valid             (wb_valid),
    .wb_tag               (wb_tag),
    .wb_value             (wb_value),
`ifdef ROB_FLUSH_EN
    .flush                (flush),
`endif
    .commit_en            (commit_en),
    .rob_commit_dst_addr  (rob_commit_dst_addr),
    .rob_commit_dst_value (rob_commit_dst_value),
    .rob_empty            (rob_empty),
    .rob_count            (rob_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dispatch_valid = 1'b0;
    wb_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic do_dispatch(input logic hd, input logic [GPR_ADDR_WIDTH-1:0] a);
    dispatch_valid    = 1'b1;
    dispatch_has_dst  = hd;
    dispatch_dst_addr = a;
    step();
    dispatch_valid    = 1'b0;
  endtask

  task automatic do_wb(input logic [ROB_PTR_WIDTH-1:0] t, input logic [WORD_WIDTH-1:0] v);
    wb_valid = 1'b1;
    wb_tag   = t;
    wb_value = v;
    step();
    wb_valid = 1'b0;
  endtask

  task automatic check_commit(input string tag, input logic en,
                              input logic [GPR_ADDR_WIDTH-1:0] a, input logic [WORD_WIDTH-1:0] v);
    check({tag, "_en"},   commit_en, en);
    check({tag, "_addr"}, rob_commit_dst_addr, a);
    check({tag, "_val"},  rob_commit_dst_value, v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    check("rst_ready", dispatch_ready, 1);
    check("rst_empty", rob_empty, 1);
    check("rst_tag",   dispatch_tag, 0);
    check("rst_count", rob_count, 0);
    check_commit("rst_commit", 0, 0, 0);

    // Single flow: dispatch x5, writeback, commit one cycle later
    do_dispatch(1'b1, 5'd5);
    check("sf_count", rob_count, 1);
    check("sf_empty", rob_empty, 0);
    check("sf_pre_commit", commit_en, 0);
    do_wb(3'd0, 32'hDEADBEEF);
    check_commit("sf_commit", 1, 5, 32'hDEADBEEF);
    step();
    check("sf_post_empty", rob_empty, 1);
    check("sf_post_commit", commit_en, 0);

    // Out-of-order completion, with tag2 written twice
    do_reset();
    check("ooo_tag0", dispatch_tag, 0);
    do_dispatch(1'b1, 5'd1);
    check("ooo_tag1", dispatch_tag, 1);
    do_dispatch(1'b1, 5'd2);
    check("ooo_tag2", dispatch_tag, 2);
    do_dispatch(1'b1, 5'd3);
    check("ooo_count", rob_count, 3);
    do_wb(3'd2, 32'h99);
    check("ooo_wait_a", commit_en, 0);
    do_wb(3'd1, 32'h11);
    check("ooo_wait_b", commit_en, 0);
    do_wb(3'd2, 32'h22);
    check("ooo_wait_c", commit_en, 0);
    do_wb(3'd0, 32'h10);
    check_commit("ooo_c0", 1, 1, 32'h10);
    step();
    check_commit("ooo_c1", 1, 2, 32'h11);
    step();
    check_commit("ooo_c2", 1, 3, 32'h22);
    step();
    check("ooo_empty", rob_empty, 1);
    check("ooo_done_commit", commit_en, 0);

    // Writeback to an unallocated slot is dropped
    do_wb(3'd3, 32'hBAD);
    check("inv_count", rob_count, 0);
    check("inv_tag", dispatch_tag, 3);
    do_dispatch(1'b1, 5'd6);
    check("inv_not_done", commit_en, 0);
    check("inv_count1", rob_count, 1);
    do_wb(3'd3, 32'h33);
    check_commit("inv_commit", 1, 6, 32'h33);
    step();
    check("inv_empty", rob_empty, 1);

    // Full and wrap
    do_reset();
    for (int i = 0; i < ROB_DEPTH; i++) begin
      dispatch_valid    = 1'b1;
      dispatch_has_dst  = 1'b1;
      dispatch_dst_addr = GPR_ADDR_WIDTH'(i + 1);
      step();
    end
    dispatch_valid = 1'b0;
    check("full_count", rob_count, 8);
    check("full_ready", dispatch_ready, 0);
    check("full_empty", rob_empty, 0);
    check("full_tag",   dispatch_tag, 0);
    do_wb(3'd0, 32'hA0);
    check_commit("full_c0", 1, 1, 32'hA0);
    check("full_ready_retire", dispatch_ready, 0);
    dispatch_valid    = 1'b1;
    dispatch_dst_addr = 5'd9;
    wb_valid = 1'b1;
    wb_tag   = 3'd1;
    wb_value = 32'hA1;
    step();
    wb_valid = 1'b0;
    check("wrap_count7", rob_count, 7);
    check("wrap_ready", dispatch_ready, 1);
    check("wrap_tag0", dispatch_tag, 0);
    check_commit("wrap_c1", 1, 2, 32'hA1);
    step();
    check("wrap_both_count", rob_count, 7);
    check("wrap_tag1", dispatch_tag, 1);
    check("wrap_no_commit", commit_en, 0);
    dispatch_dst_addr = 5'd10;
    step();
    dispatch_valid = 1'b0;
    check("wrap_count8", rob_count, 8);
    check("wrap_ready0", dispatch_ready, 0);
    check("wrap_tag2", dispatch_tag, 2);

    // x0 and no-dst entries retire without a GPR write
    do_reset();
    do_dispatch(1'b1, 5'd0);
    do_dispatch(1'b0, 5'd7);
    do_dispatch(1'b1, 5'd4);
    do_wb(3'd0, 32'h1);
    check("x0_silent", commit_en, 0);
    check("x0_count", rob_count, 3);
    do_wb(3'd1, 32'h2);
    check("nodst_silent", commit_en, 0);
    check("nodst_count", rob_count, 2);
    step();
    check_commit("nodst_zero", 0, 0, 0);
    check("nodst_count1", rob_count, 1);
    do_wb(3'd2, 32'h44);
    check_commit("after_silent", 1, 4, 32'h44);
    step();
    check("silent_empty", rob_empty, 1);

    // Asynchronous reset mid-operation
    do_dispatch(1'b1, 5'd8);
    do_dispatch(1'b1, 5'd9);
    do_wb(3'd3, 32'h55);
    check("ar_pre_commit", commit_en, 1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_count", rob_count, 0);
    check("ar_empty", rob_empty, 1);
    check("ar_commit", commit_en, 0);
    check("ar_tag", dispatch_tag, 0);
    rst = 1'b0;
    step();
    check("ar_ready", dispatch_ready, 1);

`ifdef ROB_FLUSH_EN
    // Flush: 4 entries, head completed, flush kills commit and empties buffer
    do_reset();
    for (int i = 0; i < 4; i++) begin
      do_dispatch(1'b1, GPR_ADDR_WIDTH'(i + 1));
    end
    do_wb(3'd1, 32'h11);
    do_wb(3'd2, 32'h22);
    check("fl_count4", rob_count, 4);
    do_wb(3'd0, 32'h10);
    check("fl_pre_commit", commit_en, 1);
    flush             = 1'b1;
    dispatch_valid    = 1'b1;
    dispatch_dst_addr = 5'd7;
    wb_valid = 1'b1;
    wb_tag   = 3'd3;
    wb_value = 32'h33;
    #1;
    check("fl_commit_kill", commit_en, 0);
    step();
    flush          = 1'b0;
    dispatch_valid = 1'b0;
    wb_valid       = 1'b0;
    #1;
    check("fl_count0", rob_count, 0);
    check("fl_empty", rob_empty, 1);
    check("fl_ready", dispatch_ready, 1);
    check("fl_no_commit", commit_en, 0);
    do_wb(dispatch_tag, 32'hBAD);
    check("fl_late_wb_empty", rob_empty, 1);
    do_dispatch(1'b1, 5'd9);
    check("fl_late_wb_ignored", commit_en, 0);
    check("fl_count1", rob_count, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
